guess_entry_n: RTL

- Parametrised player-2 guess-entry block for the spy guessing game.
- Player 2 keys in a WIDTH-bit guess serially on the push-buttons, then submits it.
- The guess is compared against player 1's secret; MAX_TRIES wrong submissions end the game.
- Runs on the divided game clock; outputs drive LEDR/LEDG directly.

---
 rtl/guess_entry_n.sv | 120 ++++++++++++
 1 files changed

// File: rtl/guess_entry_n.sv
// Player-2 guess entry for the spy guessing game: serial key entry, submit, compare, win/lose tracking.
// Optional macro GUESS_HINT_EN adds higher/lower hints after a wrong submission.
module guess_entry_n #(
   parameter int WIDTH     = 20,
   parameter int MAX_TRIES = 3,
   localparam int CW = $clog2(WIDTH + 1),
   localparam int TW = $clog2(MAX_TRIES + 1)
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             user_input,
   input  logic             next_input,
   input  logic             done_input,
   input  logic [WIDTH-1:0] player1_value,
   output logic [WIDTH-1:0] q,
   output logic [CW-1:0]    bit_count,
   output logic [TW-1:0]    tries_left,
   output logic             correct,
   output logic             game_over,
   output logic             hint_hi,
   output logic             hint_lo
);

   typedef enum logic [1:0] {ENTER, CHECK, WIN, LOSE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] q_n;
   logic [CW-1:0]    count_n;
   logic [TW-1:0]    tries_n;
   logic             correct_n, over_n;
   logic             prev_next, prev_done;
   logic             press_next, press_done;

   // Keys are active-low; a press is a high-to-low transition so a held key counts once.
   assign press_next = prev_next & ~next_input;
   assign press_done = prev_done & ~done_input;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state      <= ENTER;
         q          <= '0;
         bit_count  <= '0;
         tries_left <= TW'(MAX_TRIES);
         correct    <= 1'b0;
         game_over  <= 1'b0;
         prev_next  <= 1'b1;
         prev_done  <= 1'b1;
      end else begin
         state      <= state_n;
         q          <= q_n;
         bit_count  <= count_n;
         tries_left <= tries_n;
         correct    <= correct_n;
         game_over  <= over_n;
         prev_next  <= next_input;
         prev_done  <= done_input;
      end
   end

   always_comb begin
      state_n   = state;
      q_n       = q;
      count_n   = bit_count;
      tries_n   = tries_left;
      correct_n = correct;
      over_n    = game_over;
      unique case (state)
         ENTER: begin
            // A done press swallows any simultaneous next press.
            if (press_done) begin
               if (bit_count != '0) state_n = CHECK;
            end else if (press_next && bit_count < CW'(WIDTH)) begin
               q_n     = {q[WIDTH-2:0], ~user_input};
               count_n = bit_count + 1'b1;
            end
         end
         CHECK: begin
            if (q == player1_value) begin
               state_n   = WIN;
               correct_n = 1'b1;
               over_n    = 1'b1;
            end else begin
               if (tries_left != '0) tries_n = tries_left - 1'b1;
               q_n     = '0;
               count_n = '0;
               if (tries_n == '0) begin
                  state_n = LOSE;
                  over_n  = 1'b1;
               end else begin
                  state_n = ENTER;
               end
            end
         end
         WIN: ;
         LOSE: ;
      endcase
   end

`ifdef GUESS_HINT_EN
   logic hint_hi_r, hint_lo_r;

   // Every CHECK refreshes the hints; a correct guess leaves both clear.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         hint_hi_r <= 1'b0;
         hint_lo_r <= 1'b0;
      end else if (state == CHECK) begin
         hint_hi_r <= (q > player1_value);
         hint_lo_r <= (q < player1_value);
      end
   end

   assign hint_hi = hint_hi_r;
   assign hint_lo = hint_lo_r;
`else
   assign hint_hi = 1'b0;
   assign hint_lo = 1'b0;
`endif

endmodule
